// File: rtl/fp_operand_feeder.sv
// fp_operand_feeder
//   Queues (A, B) operand pairs from a producer and feeds them one pair at a
//   time to an FP wrapper over a shared tristate bus. The sequence for each pair
//   is: A on the bus until the wrapper accepts it, then B for one cycle. The
//   feeder then releases the bus, captures the result the wrapper drives back,
//   and acknowledges it. Only one pair is in flight at a time.
//
//   Optional build macro: FEEDER_DROPCNT_EN adds the dropCount port, a
//   saturating 8-bit count of pushes rejected because the FIFO was full.
//
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous, active-high reset
//   push           producer write strobe for one operand pair
//   pushA, pushB   operands of the pushed pair
//   full, empty    FIFO holds DEPTH / 0 pairs
//   bus            shared tristate data bus to the wrapper
//   inReady        operand on bus is valid (SEND_A / SEND_B)
//   inAccept       wrapper latched A and requests B
//   resultReady    wrapper is driving the result on bus
//   resultAccepted result captured; releases the wrapper (ACK)
//   result         last captured result
//   resultValid    one-cycle pulse when result updates (ACK)
//   dropCount      rejected-push count (FEEDER_DROPCNT_EN builds only)
module fp_operand_feeder #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushA,
  input  logic [WIDTH-1:0] pushB,
  output logic             full,
  output logic             empty,
  inout  wire  [WIDTH-1:0] bus,
  output logic             inReady,
  input  logic             inAccept,
  input  logic             resultReady,
  output logic             resultAccepted,
  output logic [WIDTH-1:0] result,
  output logic             resultValid
`ifdef FEEDER_DROPCNT_EN
  ,
  output logic [7:0]       dropCount
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_RES, ACK} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;

  logic             drive_a, drive_b, pop, wr_en;
  logic [WIDTH-1:0] bus_q;

  assign full  = (cnt == CNT_FULL);
  assign empty = (cnt == '0);

  // A full FIFO can still take a push in ACK: the head slot is freed at the
  // same edge, so the write lands where the pop leaves.
  assign wr_en = push & (~full | pop);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and Moore outputs
  always_comb begin
    state_nxt      = state;
    drive_a        = 1'b0;
    drive_b        = 1'b0;
    inReady        = 1'b0;
    resultAccepted = 1'b0;
    resultValid    = 1'b0;
    pop            = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) state_nxt = SEND_A;
      end
      SEND_A: begin
        drive_a = 1'b1;
        inReady = 1'b1;
        if (inAccept) state_nxt = SEND_B;
      end
      SEND_B: begin
        drive_b   = 1'b1;
        inReady   = 1'b1;
        state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        if (resultReady) state_nxt = ACK;
      end
      ACK: begin
        resultAccepted = 1'b1;
        resultValid    = 1'b1;
        pop            = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Head pair is read straight from storage; it cannot change while the FSM is
  // sending it, because the head is popped only in ACK.
  assign bus_q = drive_b ? mem_b[rd_ptr] : mem_a[rd_ptr];
  assign bus   = (drive_a | drive_b) ? bus_q : {WIDTH{1'bz}};

  // FIFO storage (data only, not reset)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_a[wr_ptr] <= pushA;
      mem_b[wr_ptr] <= pushB;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  end

  // Result capture from the bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   result <= '0;
    else if (state == WAIT_RES && resultReady) result <= bus;
  end

`ifdef FEEDER_DROPCNT_EN
  // Rejected pushes, saturating at 255
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dropCount <= '0;
    else if (push && !wr_en && dropCount != 8'hFF)
      dropCount <= dropCount + 8'd1;
  end
`endif

endmodule

// File: tb/tb_fp_operand_feeder.sv
// Self-checking bench for fp_operand_feeder. A wrapper model answers the
// feeder's handshake. A scoreboard queue holds the pairs the bench expects the
// FIFO to accept, together with the result the wrapper model will return for
// each pair.
module tb_fp_operand_feeder;

  localparam int W = 32;
  localparam int D = 4;

  logic         clk;
  logic         rst;
  logic         push;
  logic [W-1:0] pushA, pushB;
  logic         full, empty, inReady, inAccept, resultReady;
  logic         resultAccepted, resultValid;
  logic [W-1:0] result;
  wire  [W-1:0] bus;
  logic [W-1:0] drv, probe;
  logic         drv_en, probe_en;
`ifdef FEEDER_DROPCNT_EN
  logic [7:0]   dropCount;
`endif

  assign bus = drv_en   ? drv   : {W{1'bz}};
  assign bus = probe_en ? probe : {W{1'bz}};

  fp_operand_feeder #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .push(push), .pushA(pushA), .pushB(pushB),
    .full(full), .empty(empty), .bus(bus), .inReady(inReady),
    .inAccept(inAccept), .resultReady(resultReady),
    .resultAccepted(resultAccepted), .result(result), .resultValid(resultValid)
`ifdef FEEDER_DROPCNT_EN
    , .dropCount(dropCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
  } txn_t;

  txn_t sb[$];

  // Result the wrapper model returns for a pair (1.0 + 2.0 = 3.0 for the
  // directed case, an arbitrary mix otherwise).
  function automatic logic [W-1:0] resfn(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Wrapper model, acting on the falling edge.
  int   w_st;
  int   stall_target = 0;
  int   stall_cnt;
  int   res_delay = 0;
  int   res_cnt;
  txn_t cur;

  always @(negedge clk) begin
    if (rst) begin
      w_st = 0; inAccept = 1'b0; resultReady = 1'b0; drv_en = 1'b0; drv = '0;
      stall_cnt = 0; res_cnt = 0;
    end else begin
      case (w_st)
        0: if (inReady) begin
             if (sb.size() == 0) begin
               check("spurious_inReady", {31'd0, inReady}, 32'd0);
             end else begin
               cur = sb[0];
               check("busA", bus, cur.a);
               if (stall_cnt < stall_target) stall_cnt++;
               else begin inAccept = 1'b1; w_st = 1; end
             end
           end
        1: begin
             inAccept = 1'b0;
             check("inReadyB", {31'd0, inReady}, 32'd1);
             check("busB", bus, cur.b);
             w_st = 2; res_cnt = 0;
           end
        2: begin
             check("inReadyWait", {31'd0, inReady}, 32'd0);
             check("accWait", {31'd0, resultAccepted}, 32'd0);
             if (res_cnt < res_delay) res_cnt++;
             else begin drv = cur.r; drv_en = 1'b1; resultReady = 1'b1; w_st = 3; end
           end
        3: begin
             drv_en = 1'b0; resultReady = 1'b0;
             check("resultAccepted", {31'd0, resultAccepted}, 32'd1);
             check("resultValid", {31'd0, resultValid}, 32'd1);
             check("result", result, cur.r);
             void'(sb.pop_front());
             w_st = 4;
           end
        default: begin
             check("accPulse", {31'd0, resultAccepted}, 32'd0);
             check("vldPulse", {31'd0, resultValid}, 32'd0);
             check("idleGap_inReady", {31'd0, inReady}, 32'd0);
             check("resultHold", result, cur.r);
             stall_cnt = 0; w_st = 0;
           end
      endcase
    end
  end

  // Called at posedge+1; returns at the next posedge+1 with push released.
  task automatic do_push(input logic [W-1:0] a, input logic [W-1:0] b, input bit acc);
    txn_t t;
    push = 1'b1; pushA = a; pushB = b;
    if (acc) begin
      t.a = a; t.b = b; t.r = resfn(a, b);
      sb.push_back(t);
    end
    @(posedge clk); #1;
    push = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk); n++;
    end
    if (sb.size() != 0) begin
      check("timeout_pending", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc_seen, rdy_seen;
    rst = 1'b1; push = 1'b0; pushA = '0; pushB = '0; probe = '0; probe_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_inReady", {31'd0, inReady}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_resultAccepted", {31'd0, resultAccepted}, 32'd0);
    check("rst_resultValid", {31'd0, resultValid}, 32'd0);
`ifdef FEEDER_DROPCNT_EN
    check("rst_dropCount", {24'd0, dropCount}, 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Single directed pair and push-to-inReady latency
    do_push(32'h3F80_0000, 32'h4000_0000, 1'b1);
    check("lat1_inReady", {31'd0, inReady}, 32'd0);
    check("lat1_empty", {31'd0, empty}, 32'd0);
    @(posedge clk); #1;
    check("lat2_inReady", {31'd0, inReady}, 32'd1);
    wait_idle(50);
    check("empty_after_ack", {31'd0, empty}, 32'd1);

    // Fill to full, fifth push dropped, results in order
    stall_target = 5;
    for (int i = 0; i < D; i++)
      do_push(32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i), 1'b1);
    check("fill_full", {31'd0, full}, 32'd1);
    do_push(32'hDEAD_0005, 32'hBEEF_0005, 1'b0);
    check("drop_full", {31'd0, full}, 32'd1);
`ifdef FEEDER_DROPCNT_EN
    check("dropCount_one", {24'd0, dropCount}, 32'd1);
`endif
    wait_idle(300);
    check("empty_after_fill", {31'd0, empty}, 32'd1);

    // Full FIFO with a push coincident with ACK
    stall_target = 3;
    for (int i = 0; i < D; i++)
      do_push(32'h3000_0000 + 32'(i), 32'h4000_0100 + 32'(i), 1'b1);
    check("swap_full", {31'd0, full}, 32'd1);
    n = 0;
    while (!resultAccepted && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("swap_ack_seen", {31'd0, resultAccepted}, 32'd1);
    do_push(32'h3000_00FF, 32'h4000_01FF, 1'b1);
    check("swap_count_kept", {31'd0, full}, 32'd1);
    wait_idle(300);
    check("empty_after_swap", {31'd0, empty}, 32'd1);

    // Long inAccept stall in SEND_A
    stall_target = 10;
    do_push(32'h5555_AAAA, 32'h0F0F_F0F0, 1'b1);
    wait_idle(100);

    // Many drops while full and busy
    stall_target = 400;
    for (int i = 0; i < D; i++)
      do_push($urandom, $urandom, 1'b1);
    check("sat_full", {31'd0, full}, 32'd1);
    for (int i = 0; i < 300; i++)
      do_push($urandom, $urandom, 1'b0);
    check("sat_still_full", {31'd0, full}, 32'd1);
`ifdef FEEDER_DROPCNT_EN
    check("dropCount_sat", {24'd0, dropCount}, 32'd255);
`endif
    stall_target = 0;
    wait_idle(1000);

    // Reset during WAIT_RES with two pairs queued
    res_delay = 20;
    for (int i = 0; i < 3; i++)
      do_push(32'h7000_0000 + 32'(i), 32'h7100_0000 + 32'(i), 1'b1);
    n = 0;
    while (w_st != 2 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("reached_wait", 32'(w_st), 32'd2);
    #1 rst = 1'b1;
    #1;
    check("mid_inReady", {31'd0, inReady}, 32'd0);
    check("mid_empty", {31'd0, empty}, 32'd1);
    check("mid_full", {31'd0, full}, 32'd0);
    check("mid_resultValid", {31'd0, resultValid}, 32'd0);
    check("mid_result", result, 32'd0);
`ifdef FEEDER_DROPCNT_EN
    check("mid_dropCount", {24'd0, dropCount}, 32'd0);
`endif
    probe = 32'hA5A5_5A5A; probe_en = 1'b1;
    #1;
    check("mid_bus_released", bus, 32'hA5A5_5A5A);
    probe_en = 1'b0;
    sb.delete();
    res_delay = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    acc_seen = 0; rdy_seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (resultAccepted) acc_seen++;
      if (inReady) rdy_seen++;
    end
    check("post_rst_no_ack", 32'(acc_seen), 32'd0);
    check("post_rst_no_inReady", 32'(rdy_seen), 32'd0);
    check("post_rst_empty", {31'd0, empty}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
